// File: rtl/obstacle_spawner.sv
// rtl/obstacle_spawner.sv - two-slot obstacle spawner/scroller driven by an LFSR word
// Optional bird obstacles when DINO_BIRD_EN is defined.
module obstacle_spawner #(
  parameter int NUM_BITS = 8,
  parameter int X_WIDTH  = 9,
  parameter int SPAWN_X  = 320,
  parameter int MIN_GAP  = 24,
  parameter int INIT_GAP = 30
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_tick,
  input  logic                game_run,
  input  logic [2:0]          speed,
  input  logic [NUM_BITS-1:0] lfsr_data,
  output logic                lfsr_enable,
  output logic                obs0_valid,
  output logic                obs1_valid,
  output logic [X_WIDTH-1:0]  obs0_x,
  output logic [X_WIDTH-1:0]  obs1_x,
  output logic [1:0]          obs0_type,
  output logic [1:0]          obs1_type
);

  localparam int GAP_MAX = MIN_GAP + (1 << (NUM_BITS - 2)) - 1;
  localparam int CNT_MAX = (GAP_MAX > INIT_GAP) ? GAP_MAX : INIT_GAP;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [X_WIDTH-1:0] SPAWN_XV = X_WIDTH'(SPAWN_X);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WARMUP = 2'd1,
    S_RUN    = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         v_q, v_d;
  logic [X_WIDTH-1:0] x_q [2];
  logic [X_WIDTH-1:0] x_d [2];
  logic [1:0]         t_q [2];
  logic [1:0]         t_d [2];
  logic               en_q, en_d;
  logic [X_WIDTH-1:0] spd;
  logic [1:0]         spawn_type;
  logic [CNT_W-1:0]   spawn_gap;

  assign spd       = X_WIDTH'(speed);
  assign spawn_gap = CNT_W'(MIN_GAP) + CNT_W'(lfsr_data[NUM_BITS-1:2]);

`ifdef DINO_BIRD_EN
  assign spawn_type = lfsr_data[1:0];
`else
  // Without birds the top code folds onto the large cactus.
  assign spawn_type = (lfsr_data[1:0] == 2'd3) ? 2'd2 : lfsr_data[1:0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      v_q     <= '0;
      x_q[0]  <= '0;
      x_q[1]  <= '0;
      t_q[0]  <= '0;
      t_q[1]  <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      v_q     <= v_d;
      x_q[0]  <= x_d[0];
      x_q[1]  <= x_d[1];
      t_q[0]  <= t_d[0];
      t_q[1]  <= t_d[1];
      en_q    <= en_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    v_d     = v_q;
    x_d[0]  = x_q[0];
    x_d[1]  = x_q[1];
    t_d[0]  = t_q[0];
    t_d[1]  = t_q[1];

    if (!game_run) begin
      // Stopping wins over any coincident frame tick.
      state_d = S_IDLE;
      cnt_d   = '0;
      v_d     = '0;
      x_d[0]  = '0;
      x_d[1]  = '0;
      t_d[0]  = '0;
      t_d[1]  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_WARMUP;
          cnt_d   = CNT_W'(INIT_GAP);
        end
        S_WARMUP: begin
          if (frame_tick) begin
            if (cnt_q <= CNT_W'(1)) begin
              cnt_d   = '0;
              state_d = S_RUN;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end
        S_RUN: begin
          if (frame_tick) begin
            for (int i = 0; i < 2; i++) begin
              if (v_q[i]) begin
                if (x_q[i] < spd) begin
                  v_d[i] = 1'b0;
                  x_d[i] = '0;
                end else begin
                  x_d[i] = x_q[i] - spd;
                end
              end
            end
            // Spawn sees the slots as they are after this tick's scroll.
            if ((cnt_q == '0) && !(&v_d)) begin
              cnt_d = spawn_gap;
              if (!v_d[0]) begin
                v_d[0] = 1'b1;
                x_d[0] = SPAWN_XV;
                t_d[0] = spawn_type;
              end else begin
                v_d[1] = 1'b1;
                x_d[1] = SPAWN_XV;
                t_d[1] = spawn_type;
              end
            end else if (cnt_q != '0) begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    en_d = (state_d != S_IDLE);
  end

  assign lfsr_enable = en_q;
  assign obs0_valid  = v_q[0];
  assign obs1_valid  = v_q[1];
  assign obs0_x      = x_q[0];
  assign obs1_x      = x_q[1];
  assign obs0_type   = t_q[0];
  assign obs1_type   = t_q[1];

endmodule

// File: tb/tb_obstacle_spawner.sv
// tb/tb_obstacle_spawner.sv - directed and randomized checks of obstacle_spawner against a frame-level model
module tb_obstacle_spawner;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic       game_run;
  logic [2:0] speed;
  logic [7:0] lfsr_data;
  logic       lfsr_enable;
  logic       obs0_valid, obs1_valid;
  logic [8:0] obs0_x, obs1_x;
  logic [1:0] obs0_type, obs1_type;

  int total = 0;
  int bad   = 0;

  // Game-level model: phase 0 idle, 1 warmup, 2 running.
  int m_phase;
  int m_cnt;
  int m_v [2];
  int m_x [2];
  int m_t [2];
  int tk;
  int cur_sp;
  int cur_ld;

`ifdef DINO_BIRD_EN
  localparam int TOP_TYPE = 3;
`else
  localparam int TOP_TYPE = 2;
`endif

  always #5 clk = ~clk;

  obstacle_spawner dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .game_run   (game_run),
    .speed      (speed),
    .lfsr_data  (lfsr_data),
    .lfsr_enable(lfsr_enable),
    .obs0_valid (obs0_valid),
    .obs1_valid (obs1_valid),
    .obs0_x     (obs0_x),
    .obs1_x     (obs1_x),
    .obs0_type  (obs0_type),
    .obs1_type  (obs1_type)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_phase = 0;
    m_cnt   = 0;
    for (int i = 0; i < 2; i++) begin
      m_v[i] = 0;
      m_x[i] = 0;
      m_t[i] = 0;
    end
  endtask

  task automatic model_edge(input int ft, input int gr, input int sp, input int ld);
    int code;
    int slot;
    if (gr == 0) begin
      model_clear();
    end else if (m_phase == 0) begin
      m_phase = 1;
      m_cnt   = 30;
    end else if (ft != 0) begin
      if (m_phase == 1) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) m_phase = 2;
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (m_v[i] != 0) begin
            if (m_x[i] < sp) begin
              m_v[i] = 0;
              m_x[i] = 0;
            end else begin
              m_x[i] = m_x[i] - sp;
            end
          end
        end
        slot = (m_v[0] == 0) ? 0 : ((m_v[1] == 0) ? 1 : -1);
        if (m_cnt == 0 && slot >= 0) begin
          code = ld % 4;
          m_v[slot] = 1;
          m_x[slot] = 320;
          m_t[slot] = (code == 3) ? TOP_TYPE : code;
          m_cnt     = 24 + ld / 4;
        end else if (m_cnt > 0) begin
          m_cnt = m_cnt - 1;
        end
      end
    end
  endtask

  task automatic check_model();
    chk("lfsr_enable", lfsr_enable, (m_phase != 0));
    chk("obs0_valid", obs0_valid, m_v[0]);
    chk("obs1_valid", obs1_valid, m_v[1]);
    chk("obs0_x", obs0_x, m_x[0]);
    chk("obs1_x", obs1_x, m_x[1]);
    chk("obs0_type", obs0_type, m_t[0]);
    chk("obs1_type", obs1_type, m_t[1]);
  endtask

  task automatic step(input int ft, input int gr, input int sp, input int ld);
    frame_tick = ft[0];
    game_run   = gr[0];
    speed      = sp[2:0];
    lfsr_data  = ld[7:0];
    @(posedge clk);
    model_edge(ft, gr, sp, ld);
    #1;
    check_model();
  endtask

  task automatic tick();
    step(1, 1, cur_sp, cur_ld);
    tk++;
    step(0, 1, cur_sp, cur_ld);
  endtask

  task automatic stop_game();
    step(1, 0, cur_sp, cur_ld);
    chk("stop_v0", obs0_valid, 1'b0);
    chk("stop_v1", obs1_valid, 1'b0);
    chk("stop_en", lfsr_enable, 1'b0);
    step(0, 0, cur_sp, cur_ld);
  endtask

  task automatic start_game(input int sp, input int ld);
    cur_sp = sp;
    cur_ld = ld;
    tk = 0;
    step(0, 1, sp, ld);
    chk("start_en", lfsr_enable, 1'b1);
  endtask

  task automatic first_run_checks();
    start_game(2, 8'h00);
    while (tk < 30) tick();
    chk("t30_no_spawn", obs0_valid, 1'b0);
    tick();
    chk("t31_v0", obs0_valid, 1'b1);
    chk("t31_x0", obs0_x, 320);
    chk("t31_type0", obs0_type, 0);
    tick();
    chk("t32_x0", obs0_x, 318);
    while (tk < 55) tick();
    chk("t55_v1", obs1_valid, 1'b0);
    tick();
    chk("t56_v1", obs1_valid, 1'b1);
    chk("t56_x1", obs1_x, 320);
    chk("t56_x0", obs0_x, 270);
  endtask

  initial begin
    rst        = 1'b1;
    frame_tick = 1'b0;
    game_run   = 1'b0;
    speed      = 3'd0;
    lfsr_data  = 8'h00;
    cur_sp     = 0;
    cur_ld     = 0;
    tk         = 0;
    model_clear();
    #2;
    chk("rst_en", lfsr_enable, 1'b0);
    chk("rst_v0", obs0_valid, 1'b0);
    chk("rst_v1", obs1_valid, 1'b0);
    chk("rst_x0", obs0_x, 0);
    chk("rst_x1", obs1_x, 0);
    #10;
    rst = 1'b0;

    // Start, first spawn and spacing
    stop_game();
    first_run_checks();

    // All-ones word: top type and maximum gap
    stop_game();
    start_game(2, 8'hFF);
    while (tk < 31) tick();
    chk("ff_type", obs0_type, TOP_TYPE);
    while (tk < 118) tick();
    chk("ff_t118_v1", obs1_valid, 1'b0);
    tick();
    chk("ff_t119_v1", obs1_valid, 1'b1);
    chk("ff_t119_type1", obs1_type, TOP_TYPE);

    // Retire at speed 7
    stop_game();
    start_game(7, 8'hFF);
    while (tk < 76) tick();
    chk("ret_x5", obs0_x, 5);
    chk("ret_v_still", obs0_valid, 1'b1);
    tick();
    chk("ret_v0", obs0_valid, 1'b0);
    chk("ret_x0", obs0_x, 0);

    // Both slots full at speed 0, then release
    stop_game();
    start_game(0, 8'h00);
    while (tk < 100) tick();
    chk("full_v0", obs0_valid, 1'b1);
    chk("full_v1", obs1_valid, 1'b1);
    chk("full_x0", obs0_x, 320);
    chk("full_x1", obs1_x, 320);
    cur_sp = 7;
    while (tk < 145) tick();
    chk("full_x5", obs0_x, 5);
    tick();
    chk("respawn_v0", obs0_valid, 1'b1);
    chk("respawn_x0", obs0_x, 320);
    chk("respawn_v1", obs1_valid, 1'b0);

    // Stop on a tick, then restart gives the same sequence
    stop_game();
    first_run_checks();

    // Asynchronous reset between edges while running
    #2;
    rst = 1'b1;
    #1;
    chk("arst_en", lfsr_enable, 1'b0);
    chk("arst_v0", obs0_valid, 1'b0);
    chk("arst_v1", obs1_valid, 1'b0);
    chk("arst_x0", obs0_x, 0);
    chk("arst_x1", obs1_x, 0);
    model_clear();
    #2;
    rst = 1'b0;
    start_game(3, 8'h5A);
    while (tk < 40) tick();

    // Randomized play
    cur_sp = 2;
    cur_ld = 0;
    for (int n = 0; n < 4000; n++) begin
      int ft;
      int gr;
      ft = ($urandom_range(0, 2) == 0) ? 1 : 0;
      gr = ($urandom_range(0, 299) == 0) ? 0 : 1;
      if ($urandom_range(0, 49) == 0) cur_sp = $urandom_range(0, 7);
      cur_ld = $urandom_range(0, 255);
      step(ft, gr, cur_sp, cur_ld);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/obstacle_spawner.md
# obstacle_spawner

Consumes the pseudo-random word from the LFSR and turns it into the game's obstacle stream. It manages two obstacle slots, spawning at random intervals with random types and scrolling them left once per frame. It also drives the LFSR's `enable`, so every game starts from the same LFSR seed. Its outputs feed the renderer and collision logic.

## Interface
- `NUM_BITS`, 8: LFSR word width; must be ≥ 4.
- `X_WIDTH`, 9: obstacle x-coordinate width.
- `SPAWN_X`, 320: x position of a newly spawned obstacle (right screen edge).
- `MIN_GAP`, 24: minimum frames reloaded between spawns.
- `INIT_GAP`, 30: obstacle-free frames at game start.

- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `frame_tick`  in  1  one-cycle pulse per video frame.
- `game_run`  in  1  high while a game is in play.
- `speed`  in  3  scroll speed in pixels per frame, 0..7.
- `lfsr_data`  in  NUM_BITS  LFSR output word.
- `lfsr_enable`  out  1  drives the LFSR `enable` input.
- `obs0_valid`, `obs1_valid`  out  1  slot occupied.
- `obs0_x`, `obs1_x`  out  X_WIDTH  slot x position.
- `obs0_type`, `obs1_type`  out  2  slot type: 0/1 = small cactus, 2 = large cactus, 3 = bird.

## Operation
- **Reset:** state IDLE; all outputs 0; frame counter 0.
- **States:**
  - IDLE: slots cleared; `lfsr_enable` = 0, which holds the LFSR at its seed.
  - WARMUP: frame counter counts frame ticks.
  - RUN: spawn and scroll active.
- **Transitions:**
  - IDLE→WARMUP when `game_run` = 1; the counter loads `INIT_GAP`.
  - WARMUP: each frame tick decrements the counter. The tick that makes it 0 moves the block to RUN with the counter at 0. No spawn occurs on that tick.
  - Any state→IDLE on the first clock with `game_run` = 0. This overrides a simultaneous `frame_tick`; slots and counter clear on the same edge.
- **RUN, per frame tick, in this order:**
  1. Scroll: for each valid slot, if `x < speed`, clear valid and set x = 0 (retire). Otherwise x = x − speed. Retire when `x == speed` gives x = 0, still valid. With `speed` = 0 obstacles never move or retire.
  2. Spawn: if counter = 0 and a slot is free after step 1, fill the lowest-index free slot.
     - x = `SPAWN_X`.
     - Type from `lfsr_data[1:0]`.
     - Counter loads `MIN_GAP + lfsr_data[NUM_BITS-1:2]`.
     - The new obstacle is not scrolled on its spawn tick.
  3. Else if counter ≠ 0, decrement it.
  4. Else (counter = 0, no free slot), hold at 0; spawn occurs on the first tick a slot is free.
- **Spawn spacing:** loaded gap + 1 frames.
- **Counter width:** wide enough for `MIN_GAP + 2^(NUM_BITS-2) − 1`; 7 bits minimum at defaults. Unsigned arithmetic; no wrap.
- `frame_tick` is ignored in IDLE.

## Timing
- All outputs are registered. Slot updates from a frame tick are visible in the cycle after that tick.
- `lfsr_enable` = 1 in WARMUP and RUN, 0 in IDLE. It rises the cycle after `game_run` is first sampled high.
- `lfsr_data` is sampled only on the spawn edge.
- `rst` clears all state immediately, regardless of `clk`. Deassertion returns the block to IDLE.

## Configuration
- Macro: `DINO_BIRD_EN`.
- Defined: `lfsr_data[1:0]` = 3 spawns type 3 (bird).
- Undefined: code 3 maps to type 2 (large cactus); `obsN_type` never equals 3.
- Gap and x behaviour are identical in both builds.

## Test plan
Defaults apply throughout; frame ticks are counted from `game_run` rising.
- **Start and first spawn:** `lfsr_data` = 8'h00, `speed` = 2.
  - Ticks 1–30: no spawn.
  - Tick 31: obs0 valid, x = 320, type 0.
  - Tick 32: obs0 x = 318.
  - Tick 56: obs1 valid, x = 320; obs0 x = 270.
- **Type and gap with `lfsr_data` = 8'hFF:**
  - First spawn: type 3 with `DINO_BIRD_EN`, type 2 without.
  - Next spawn follows 88 frames later.
- **Retire:** `speed` = 7, single obstacle.
  - After 45 ticks: x = 5, still valid.
  - Tick 46: valid = 0, x = 0.
  - A same-tick spawn, if due, lands in slot 0.
- **Slots full:** `speed` = 0.
  - After both slots fill, the counter holds at 0 and no third spawn occurs.
  - Then set `speed` = 7: the first retire tick re-spawns immediately at x = 320.
- **Stop:** drop `game_run` on a `frame_tick` cycle.
  - Next cycle: all valids 0, `lfsr_enable` 0.
  - Restart gives the identical sequence as the first run.
- **Async reset mid-RUN:** assert `rst` between clock edges.
  - All outputs go to 0 without waiting for a clock edge.
  - State returns to IDLE.
